stamofu_aq_wide: RTL and testbench
==================================

Name: stamofu_aq_wide

Overview:
- Next-generation Store-AMO-Fence Unit acquire queue: in-order shift queue of acquire-carrying ops (mem and/or io acquire) indexed by ROB index.
- Accepts up to ENQ_WIDTH ops per cycle and UPDATE_BANKS acquire-update channels, tracks ROB kills, and dequeues one op per cycle in order.
- Advertises the oldest live mem-acquire and oldest live io-acquire ROB index to the load/issue side, plus an occupancy count, all registered.

Parameters:
- STAMOFU_AQ_ENTRIES, 8, queue depth (>=2).
- ENQ_WIDTH, 2, enqueue lanes per cycle (1..STAMOFU_AQ_ENTRIES).
- UPDATE_BANKS, 2, independent update channels (>=1).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous, active-low; clock CLK.
- enq_valid  in  ENQ_WIDTH  per-lane enqueue valid; set lanes must be contiguous from lane 0.
- enq_mem_aq  in  ENQ_WIDTH  per-lane mem acquire.
- enq_io_aq  in  ENQ_WIDTH  per-lane io acquire.
- enq_ROB_index  in  ENQ_WIDTH x LOG_ROB_ENTRIES  per-lane ROB index; lane 0 is oldest.
- enq_ready  out  1  free entries >= ENQ_WIDTH.
- update_valid  in  UPDATE_BANKS  per-bank update valid.
- update_mem_aq  in  UPDATE_BANKS  new mem acquire value.
- update_io_aq  in  UPDATE_BANKS  new io acquire value.
- update_ROB_index  in  UPDATE_BANKS x LOG_ROB_ENTRIES  target ROB index.
- deq_valid  in  1  pop head.
- deq_ROB_index  out  LOG_ROB_ENTRIES  head ROB index (entry 0), combinational.
- deq_empty  out  1  no valid entries.
- rob_abs_head_index  in  LOG_ROB_ENTRIES  ROB head.
- rob_kill_valid  in  1  kill event.
- rob_kill_rel_kill_younger_index  in  LOG_ROB_ENTRIES  relative kill boundary.
- mem_aq_active / io_aq_active  out  1  a live acquire of that type exists.
- mem_aq_oldest_abs_ROB_index / io_aq_oldest_abs_ROB_index  out  LOG_ROB_ENTRIES  ROB index of the oldest such entry.
- occupancy  out  $clog2(STAMOFU_AQ_ENTRIES+1)  registered valid-entry count.

Behaviour:
- Storage: entry 0 is oldest. Per-entry valid, killed, mem_aq, io_aq, ROB_index. Valid entries always form a prefix 0..occ-1.
- Enqueue:
  - Accepted only when enq_ready is high; with enq_ready low, all lanes are ignored (no partial accept).
  - Lane k is written to entry occ-deq+k, where deq is 1 if deq_valid and the queue is non-empty. New entries have killed=0.
- Dequeue: deq_valid shifts every entry down by one. deq_valid while empty is ignored and occ stays 0.
- Same-cycle dequeue and enqueue: the write slots account for the shift; occ_next = occ - deq + accepted lanes, never exceeding STAMOFU_AQ_ENTRIES.
- Kill:
  - Entry newly killed when rob_kill_valid and (ROB_index - rob_abs_head_index) mod 2^LOG_ROB_ENTRIES >= rel_kill_younger_index.
  - Killed is sticky and moves with the entry on shift.
  - Killed entries stay in the queue until dequeued. Ops enqueued in the kill cycle are not checked.
- Update:
  - Every valid entry whose ROB_index equals update_ROB_index[b] takes that bank's mem_aq and io_aq. This applies to shifting entries, which carry the updated value.
  - If several banks match one entry, the lowest-numbered bank wins.
  - An update does not match a same-cycle enqueue.
- Advertisement:
  - Live = valid & ~killed & flag. Priority-select the lowest-index live entry per type.
  - Outputs are registered from current state, so latency is 1 cycle after the state change.
  - When no live entry exists, active=0 and the ROB index is the value muxed from entry 0 (don't-care).
- Reset (synchronous nRST low): all valid/killed/flag bits and ROB indices 0; all outputs 0; enq_ready=1; deq_empty=1. Mid-operation reset discards all entries.
- Wrap-around: all ROB arithmetic is modulo 2^LOG_ROB_ENTRIES.

Optional Feature:
- Macro STAMOFU_AQ_DEQ_CHECK_EN.
- Defined: adds inputs deq_check_ROB_index [LOG_ROB_ENTRIES] and output deq_mismatch (1). deq_mismatch is registered and set the cycle after a deq_valid where the check index differs from the head ROB index, or where the queue is empty. It is sticky until reset.
- Undefined: no extra ports, no check logic.

Decomposition:
- core_types_pkg provides LOG_ROB_ENTRIES. Add a stamofu_aq_entry_t struct {valid, killed, mem_aq, io_aq, ROB_index} to core_types_pkg.
- Reuse the existing pe_lsb for the two oldest-acquire selects.
- Natural sub-module: stamofu_aq_entry_update — per-entry combinational next-value from kill and update-bank matches, instantiated once per entry.

Test Plan:
- Reset, then enqueue lanes {ROB 5 mem, ROB 6 io} -> next cycle occupancy=2. One cycle later mem_aq_oldest=5 with mem active=1, and io_aq_oldest=6 with io active=1.
- Fill 8 entries (ENQ_WIDTH=2) -> enq_ready=0 at occ>=7. Enqueue attempt at occ=7 is ignored; occ stays 7. Dequeue plus 2-lane enqueue at occ=6 -> occ=7.
- Head=60, entries ROB 62,63,0,1 (wrap), kill rel=3 -> ROB 63,0,1 killed, 62 live. mem_aq_active tracks only ROB 62.
- Banks 0 and 1 both update ROB 9 (mem=0 vs mem=1) on the same cycle as a dequeue shift -> the shifted entry holds bank 0's value.
- deq_valid on an empty queue -> occ stays 0, deq_empty=1. With the macro defined, deq_mismatch=1 next cycle.
- Assert nRST mid-stream with 5 entries -> next cycle all outputs 0, enq_ready=1.

Source files
------------

// File: rtl/core_types_pkg.sv
// Core-wide types shared by the store/AMO/fence pipeline.
// Holds ROB sizing and the acquire-queue entry layout.
package core_types_pkg;

  localparam int unsigned LOG_ROB_ENTRIES = 6;

  typedef struct packed {
    logic                       valid;
    logic                       killed;
    logic                       mem_aq;
    logic                       io_aq;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } stamofu_aq_entry_t;

endpackage

// File: rtl/stamofu_aq_wide_if.sv
// Handshake/bus bundle for stamofu_aq_wide. Optional deq check ports exist only
// when STAMOFU_AQ_DEQ_CHECK_EN is defined.
interface stamofu_aq_wide_if #(
  parameter int unsigned STAMOFU_AQ_ENTRIES = 8,
  parameter int unsigned ENQ_WIDTH          = 2,
  parameter int unsigned UPDATE_BANKS       = 2
);
  import core_types_pkg::*;

  localparam int unsigned OCC_W = $clog2(STAMOFU_AQ_ENTRIES + 1);

  logic [ENQ_WIDTH-1:0]                          enq_valid;
  logic [ENQ_WIDTH-1:0]                          enq_mem_aq;
  logic [ENQ_WIDTH-1:0]                          enq_io_aq;
  logic [ENQ_WIDTH-1:0][LOG_ROB_ENTRIES-1:0]     enq_ROB_index;
  logic                                          enq_ready;
  logic [UPDATE_BANKS-1:0]                       update_valid;
  logic [UPDATE_BANKS-1:0]                       update_mem_aq;
  logic [UPDATE_BANKS-1:0]                       update_io_aq;
  logic [UPDATE_BANKS-1:0][LOG_ROB_ENTRIES-1:0]  update_ROB_index;
  logic                                          deq_valid;
  logic [LOG_ROB_ENTRIES-1:0]                    deq_ROB_index;
  logic                                          deq_empty;
  logic [LOG_ROB_ENTRIES-1:0]                    rob_abs_head_index;
  logic                                          rob_kill_valid;
  logic [LOG_ROB_ENTRIES-1:0]                    rob_kill_rel_kill_younger_index;
  logic                                          mem_aq_active;
  logic [LOG_ROB_ENTRIES-1:0]                    mem_aq_oldest_abs_ROB_index;
  logic                                          io_aq_active;
  logic [LOG_ROB_ENTRIES-1:0]                    io_aq_oldest_abs_ROB_index;
  logic [OCC_W-1:0]                              occupancy;
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
  logic [LOG_ROB_ENTRIES-1:0]                    deq_check_ROB_index;
  logic                                          deq_mismatch;
`endif

  modport master (
    output enq_valid, enq_mem_aq, enq_io_aq, enq_ROB_index,
    output update_valid, update_mem_aq, update_io_aq, update_ROB_index,
    output deq_valid, rob_abs_head_index, rob_kill_valid, rob_kill_rel_kill_younger_index,
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    output deq_check_ROB_index,
    input  deq_mismatch,
`endif
    input  enq_ready, deq_ROB_index, deq_empty,
    input  mem_aq_active, mem_aq_oldest_abs_ROB_index,
    input  io_aq_active, io_aq_oldest_abs_ROB_index, occupancy
  );

  modport slave (
    input  enq_valid, enq_mem_aq, enq_io_aq, enq_ROB_index,
    input  update_valid, update_mem_aq, update_io_aq, update_ROB_index,
    input  deq_valid, rob_abs_head_index, rob_kill_valid, rob_kill_rel_kill_younger_index,
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    input  deq_check_ROB_index,
    output deq_mismatch,
`endif
    output enq_ready, deq_ROB_index, deq_empty,
    output mem_aq_active, mem_aq_oldest_abs_ROB_index,
    output io_aq_active, io_aq_oldest_abs_ROB_index, occupancy
  );

endinterface

// File: rtl/pe_lsb.sv
// Priority encoder: index of the lowest set request bit.
// index is 0 when no request is present.
module pe_lsb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]         req,
  output logic                     present,
  output logic [$clog2(WIDTH)-1:0] index
);

  localparam int unsigned IW = $clog2(WIDTH);

  always_comb begin
    present = |req;
    index   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/stamofu_aq_entry_update.sv
// Per-entry next value from ROB kill and acquire-update bank matches.
// Lowest-numbered matching bank wins.
module stamofu_aq_entry_update
  import core_types_pkg::*;
#(
  parameter int unsigned UPDATE_BANKS = 2
) (
  input  stamofu_aq_entry_t                             entry,
  input  logic [LOG_ROB_ENTRIES-1:0]                    rob_abs_head_index,
  input  logic                                          rob_kill_valid,
  input  logic [LOG_ROB_ENTRIES-1:0]                    rob_kill_rel_kill_younger_index,
  input  logic [UPDATE_BANKS-1:0]                       update_valid,
  input  logic [UPDATE_BANKS-1:0]                       update_mem_aq,
  input  logic [UPDATE_BANKS-1:0]                       update_io_aq,
  input  logic [UPDATE_BANKS-1:0][LOG_ROB_ENTRIES-1:0]  update_ROB_index,
  output stamofu_aq_entry_t                             entry_next
);

  logic [LOG_ROB_ENTRIES-1:0] rel_index;

  // Modulo ROB distance from head; wraps naturally at the ROB size.
  assign rel_index = entry.ROB_index - rob_abs_head_index;

  always_comb begin
    entry_next = entry;
    if (entry.valid) begin
      if (rob_kill_valid && (rel_index >= rob_kill_rel_kill_younger_index)) begin
        entry_next.killed = 1'b1;
      end
      // Descending scan so the lowest-numbered match is applied last.
      for (int b = int'(UPDATE_BANKS) - 1; b >= 0; b--) begin
        if (update_valid[b] && (update_ROB_index[b] == entry.ROB_index)) begin
          entry_next.mem_aq = update_mem_aq[b];
          entry_next.io_aq  = update_io_aq[b];
        end
      end
    end
  end

endmodule

// File: rtl/stamofu_aq_wide.sv
// In-order acquire shift queue with wide enqueue, banked updates and registered
// oldest-acquire advertisement. Optional head check: STAMOFU_AQ_DEQ_CHECK_EN.
module stamofu_aq_wide
  import core_types_pkg::*;
#(
  parameter int unsigned STAMOFU_AQ_ENTRIES = 8,
  parameter int unsigned ENQ_WIDTH          = 2,
  parameter int unsigned UPDATE_BANKS       = 2
) (
  input logic              CLK,
  input logic              nRST,
  stamofu_aq_wide_if.slave aq
);

  localparam int unsigned N     = STAMOFU_AQ_ENTRIES;
  localparam int unsigned OCC_W = $clog2(N + 1);
  localparam int unsigned IDX_W = $clog2(N);

  stamofu_aq_entry_t          entries_q   [N];
  stamofu_aq_entry_t          entries_d   [N];
  stamofu_aq_entry_t          entries_upd [N+1];
  logic [OCC_W-1:0]           occ_q, occ_d, base, enq_count;
  logic                       deq, enq_ready;
  logic [N-1:0]               mem_live, io_live;
  logic                       mem_present, io_present;
  logic [IDX_W-1:0]           mem_idx, io_idx;
  logic                       mem_active_q, io_active_q;
  logic [LOG_ROB_ENTRIES-1:0] mem_oldest_q, io_oldest_q;

  for (genvar i = 0; i < int'(N); i++) begin : g_entry
    stamofu_aq_entry_update #(
      .UPDATE_BANKS(UPDATE_BANKS)
    ) u_entry_update (
      .entry                           (entries_q[i]),
      .rob_abs_head_index              (aq.rob_abs_head_index),
      .rob_kill_valid                  (aq.rob_kill_valid),
      .rob_kill_rel_kill_younger_index (aq.rob_kill_rel_kill_younger_index),
      .update_valid                    (aq.update_valid),
      .update_mem_aq                   (aq.update_mem_aq),
      .update_io_aq                    (aq.update_io_aq),
      .update_ROB_index                (aq.update_ROB_index),
      .entry_next                      (entries_upd[i])
    );
    assign mem_live[i] = entries_q[i].valid & ~entries_q[i].killed & entries_q[i].mem_aq;
    assign io_live[i]  = entries_q[i].valid & ~entries_q[i].killed & entries_q[i].io_aq;
  end
  assign entries_upd[N] = '0;

  assign enq_ready = (int'(occ_q) + int'(ENQ_WIDTH)) <= int'(N);
  assign deq       = aq.deq_valid & entries_q[0].valid;

  always_comb begin
    enq_count = '0;
    for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
      if (enq_ready && aq.enq_valid[k]) enq_count = enq_count + 1'b1;
    end
    base = occ_q - OCC_W'(deq);
    for (int i = 0; i < int'(N); i++) begin
      entries_d[i] = deq ? entries_upd[i+1] : entries_upd[i];
      // Enqueue slots are placed after the post-shift tail.
      for (int k = 0; k < int'(ENQ_WIDTH); k++) begin
        if (enq_ready && aq.enq_valid[k] && (int'(base) + k == i)) begin
          entries_d[i].valid     = 1'b1;
          entries_d[i].killed    = 1'b0;
          entries_d[i].mem_aq    = aq.enq_mem_aq[k];
          entries_d[i].io_aq     = aq.enq_io_aq[k];
          entries_d[i].ROB_index = aq.enq_ROB_index[k];
        end
      end
    end
    occ_d = base + enq_count;
  end

  pe_lsb #(.WIDTH(N)) u_mem_pe (.req(mem_live), .present(mem_present), .index(mem_idx));
  pe_lsb #(.WIDTH(N)) u_io_pe  (.req(io_live),  .present(io_present),  .index(io_idx));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < int'(N); i++) entries_q[i] <= '0;
      occ_q        <= '0;
      mem_active_q <= 1'b0;
      io_active_q  <= 1'b0;
      mem_oldest_q <= '0;
      io_oldest_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) entries_q[i] <= entries_d[i];
      occ_q        <= occ_d;
      mem_active_q <= mem_present;
      io_active_q  <= io_present;
      mem_oldest_q <= entries_q[mem_idx].ROB_index;
      io_oldest_q  <= entries_q[io_idx].ROB_index;
    end
  end

  assign aq.enq_ready                   = enq_ready;
  assign aq.deq_ROB_index               = entries_q[0].ROB_index;
  assign aq.deq_empty                   = ~entries_q[0].valid;
  assign aq.mem_aq_active               = mem_active_q;
  assign aq.mem_aq_oldest_abs_ROB_index = mem_oldest_q;
  assign aq.io_aq_active                = io_active_q;
  assign aq.io_aq_oldest_abs_ROB_index  = io_oldest_q;
  assign aq.occupancy                   = occ_q;

`ifdef STAMOFU_AQ_DEQ_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mismatch_q <= 1'b0;
    end else if (aq.deq_valid &&
                 (!entries_q[0].valid || (aq.deq_check_ROB_index != entries_q[0].ROB_index))) begin
      mismatch_q <= 1'b1;
    end
  end

  assign aq.deq_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_stamofu_aq_wide.sv
// Scoreboard bench for stamofu_aq_wide: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_stamofu_aq_wide;
  import core_types_pkg::*;

  typedef enum int {SigOcc, SigReady, SigEmpty, SigDeqIdx, SigMemAct, SigMemIdx,
                    SigIoAct, SigIoIdx, SigMismatch} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  stamofu_aq_wide_if #(.STAMOFU_AQ_ENTRIES(8), .ENQ_WIDTH(2), .UPDATE_BANKS(2)) aq_if ();

  stamofu_aq_wide #(
    .STAMOFU_AQ_ENTRIES(8),
    .ENQ_WIDTH         (2),
    .UPDATE_BANKS      (2)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .aq  (aq_if)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic void chk(input int d, input sig_e s, input logic [31:0] v,
                              input string n);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SigOcc:    return 32'(aq_if.occupancy);
      SigReady:  return 32'(aq_if.enq_ready);
      SigEmpty:  return 32'(aq_if.deq_empty);
      SigDeqIdx: return 32'(aq_if.deq_ROB_index);
      SigMemAct: return 32'(aq_if.mem_aq_active);
      SigMemIdx: return 32'(aq_if.mem_aq_oldest_abs_ROB_index);
      SigIoAct:  return 32'(aq_if.io_aq_active);
      SigIoIdx:  return 32'(aq_if.io_aq_oldest_abs_ROB_index);
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
      SigMismatch: return 32'(aq_if.deq_mismatch);
`endif
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge CLK) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(exp_q[i].sig);
        n_total++;
        if (act === exp_q[i].val) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d",
                      exp_q[i].name, cyc, act, exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    aq_if.enq_valid      = '0;
    aq_if.update_valid   = '0;
    aq_if.deq_valid      = 1'b0;
    aq_if.rob_kill_valid = 1'b0;
  endtask

  task automatic drive_enq(input logic [1:0] v, input logic [1:0] mem, input logic [1:0] io,
                           input logic [5:0] r0, input logic [5:0] r1);
    aq_if.enq_valid        = v;
    aq_if.enq_mem_aq       = mem;
    aq_if.enq_io_aq        = io;
    aq_if.enq_ROB_index[0] = r0;
    aq_if.enq_ROB_index[1] = r1;
  endtask

  task automatic drive_deq(input logic [5:0] head);
    aq_if.deq_valid = 1'b1;
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    aq_if.deq_check_ROB_index = head;
`else
    if (head === 6'bx) aq_if.deq_valid = 1'b1;
`endif
  endtask

  initial begin
    logic [5:0] kheads [3];
    kheads = '{6'd63, 6'd0, 6'd1};
    nRST = 1'b0;
    idle();
    aq_if.enq_mem_aq = '0;
    aq_if.enq_io_aq = '0;
    aq_if.enq_ROB_index = '0;
    aq_if.update_mem_aq = '0;
    aq_if.update_io_aq = '0;
    aq_if.update_ROB_index = '0;
    aq_if.rob_abs_head_index = '0;
    aq_if.rob_kill_rel_kill_younger_index = '0;
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    aq_if.deq_check_ROB_index = '0;
`endif
    repeat (2) step();
    nRST = 1'b1;

    n_total++;
    if (aq_if.occupancy === '0) n_pass++;
    else $display("FAIL direct_rst_occ: got %0d expected 0", aq_if.occupancy);
    n_total++;
    if (aq_if.enq_ready === 1'b1) n_pass++;
    else $display("FAIL direct_rst_ready: got %0d expected 1", aq_if.enq_ready);
    n_total++;
    if (aq_if.deq_empty === 1'b1) n_pass++;
    else $display("FAIL direct_rst_empty: got %0d expected 1", aq_if.deq_empty);

    chk(0, SigOcc, 0, "rst_occ");
    chk(0, SigReady, 1, "rst_ready");
    chk(0, SigEmpty, 1, "rst_empty");
    chk(0, SigMemAct, 0, "rst_mem_act");
    chk(0, SigIoAct, 0, "rst_io_act");
    chk(0, SigDeqIdx, 0, "rst_deq_idx");

    // Two-lane enqueue: ROB 5 mem, ROB 6 io.
    drive_enq(2'b11, 2'b01, 2'b10, 6'd5, 6'd6);
    chk(1, SigOcc, 2, "enq2_occ");
    chk(1, SigDeqIdx, 5, "enq2_head");
    chk(1, SigEmpty, 0, "enq2_empty");
    chk(2, SigMemAct, 1, "enq2_mem_act");
    chk(2, SigMemIdx, 5, "enq2_mem_idx");
    chk(2, SigIoAct, 1, "enq2_io_act");
    chk(2, SigIoIdx, 6, "enq2_io_idx");
    step();

    // Fill to 8.
    idle(); drive_enq(2'b11, 2'b00, 2'b00, 6'd7, 6'd8);
    chk(1, SigOcc, 4, "fill_occ4"); step();
    idle(); drive_enq(2'b11, 2'b00, 2'b00, 6'd9, 6'd10);
    chk(1, SigOcc, 6, "fill_occ6"); chk(1, SigReady, 1, "fill_ready6"); step();
    idle(); drive_enq(2'b11, 2'b00, 2'b00, 6'd11, 6'd12);
    chk(1, SigOcc, 8, "fill_occ8"); chk(1, SigReady, 0, "full_ready"); step();

    idle(); drive_deq(6'd5);
    chk(1, SigOcc, 7, "deq_occ7"); chk(1, SigReady, 0, "occ7_ready");
    chk(1, SigDeqIdx, 6, "deq_head6");
    chk(2, SigMemAct, 0, "deq_mem_gone"); chk(2, SigIoAct, 1, "deq_io_act");
    chk(2, SigIoIdx, 6, "deq_io_idx"); step();

    // Enqueue while not ready is dropped entirely.
    idle(); drive_enq(2'b11, 2'b11, 2'b00, 6'd13, 6'd14);
    chk(1, SigOcc, 7, "noready_occ"); chk(1, SigDeqIdx, 6, "noready_head");
    chk(2, SigMemAct, 0, "noready_mem_act"); step();

    idle(); drive_deq(6'd6);
    chk(1, SigOcc, 6, "deq_occ6"); chk(1, SigReady, 1, "occ6_ready");
    chk(1, SigDeqIdx, 7, "deq_head7"); chk(2, SigIoAct, 0, "io_gone"); step();

    // Dequeue plus two-lane enqueue at occ 6.
    idle(); drive_deq(6'd7); drive_enq(2'b11, 2'b01, 2'b00, 6'd13, 6'd14);
    chk(1, SigOcc, 7, "deqenq_occ"); chk(1, SigDeqIdx, 8, "deqenq_head");
    chk(2, SigMemAct, 1, "deqenq_mem_act"); chk(2, SigMemIdx, 13, "deqenq_mem_idx"); step();

    for (int j = 1; j <= 7; j++) begin
      idle(); drive_deq(6'(7 + j));
      chk(1, SigOcc, 32'(7 - j), "drain_occ");
      if (j < 7) chk(1, SigDeqIdx, 32'(8 + j), "drain_head");
      else chk(1, SigEmpty, 1, "drain_empty");
      step();
    end

    // Kill across the ROB wrap: head 60, entries 62,63,0,1, rel 3.
    idle(); aq_if.rob_abs_head_index = 6'd60;
    drive_enq(2'b11, 2'b11, 2'b00, 6'd62, 6'd63); step();
    idle(); drive_enq(2'b11, 2'b11, 2'b00, 6'd0, 6'd1);
    chk(1, SigOcc, 4, "kill_fill_occ"); step();
    idle(); aq_if.rob_kill_valid = 1'b1; aq_if.rob_kill_rel_kill_younger_index = 6'd3;
    chk(2, SigMemAct, 1, "kill_mem_act62"); chk(2, SigMemIdx, 62, "kill_mem_idx62"); step();
    idle(); step();
    idle(); drive_deq(6'd62);
    chk(1, SigOcc, 3, "kill_stay_occ"); chk(1, SigDeqIdx, 63, "kill_head63");
    chk(2, SigMemAct, 0, "killed_not_live"); step();
    for (int j = 0; j < 3; j++) begin
      idle(); drive_deq(kheads[j]);
      chk(1, SigOcc, 32'(2 - j), "kill_drain_occ");
      chk(2, SigMemAct, 0, "kill_drain_mem_act");
      step();
    end

    // Dual-bank update on ROB 9 during a shift: bank 0 wins.
    idle(); drive_enq(2'b11, 2'b10, 2'b00, 6'd20, 6'd9);
    chk(2, SigMemAct, 1, "upd_pre_mem_act"); chk(2, SigMemIdx, 9, "upd_pre_mem_idx");
    chk(2, SigIoAct, 0, "upd_pre_io_act"); step();
    idle(); drive_deq(6'd20);
    aq_if.update_valid = 2'b11;
    aq_if.update_ROB_index[0] = 6'd9; aq_if.update_ROB_index[1] = 6'd9;
    aq_if.update_mem_aq = 2'b10; aq_if.update_io_aq = 2'b01;
    chk(1, SigDeqIdx, 9, "upd_head"); chk(1, SigOcc, 1, "upd_occ");
    chk(2, SigMemAct, 0, "upd_bank0_mem"); chk(2, SigIoAct, 1, "upd_bank0_io");
    chk(2, SigIoIdx, 9, "upd_io_idx"); step();
    // Update aimed at a same-cycle enqueue has no effect on it.
    idle(); drive_enq(2'b01, 2'b01, 2'b00, 6'd30, 6'd0);
    aq_if.update_valid = 2'b01; aq_if.update_ROB_index[0] = 6'd30;
    aq_if.update_mem_aq = 2'b00; aq_if.update_io_aq = 2'b01;
    chk(1, SigOcc, 2, "updenq_occ");
    chk(2, SigMemAct, 1, "updenq_mem_act"); chk(2, SigMemIdx, 30, "updenq_mem_idx");
    chk(2, SigIoAct, 1, "updenq_io_act"); chk(2, SigIoIdx, 9, "updenq_io_idx"); step();
    idle(); drive_deq(6'd9);
    chk(1, SigDeqIdx, 30, "upd_drain_head"); chk(2, SigIoAct, 0, "upd_drain_io");
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    chk(1, SigMismatch, 0, "mismatch_clean");
`endif
    step();
    idle(); drive_deq(6'd30); chk(1, SigOcc, 0, "upd_drain_occ"); step();

    // Dequeue on empty.
    idle(); drive_deq(6'd0);
    chk(1, SigOcc, 0, "empty_deq_occ"); chk(1, SigEmpty, 1, "empty_deq_empty");
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    chk(1, SigMismatch, 1, "empty_deq_mismatch");
`endif
    step();

    // Mid-stream reset with 5 entries.
    idle(); drive_enq(2'b11, 2'b00, 2'b00, 6'd1, 6'd2); step();
    idle(); drive_enq(2'b11, 2'b00, 2'b00, 6'd3, 6'd4); step();
    idle(); drive_enq(2'b01, 2'b01, 2'b00, 6'd5, 6'd0);
    chk(1, SigOcc, 5, "pre_rst_occ"); chk(2, SigMemAct, 1, "pre_rst_mem_act"); step();
    idle(); step();
    idle(); drive_enq(2'b11, 2'b11, 2'b11, 6'd7, 6'd8); nRST = 1'b0;
    chk(1, SigOcc, 0, "mrst_occ"); chk(1, SigReady, 1, "mrst_ready");
    chk(1, SigEmpty, 1, "mrst_empty"); chk(1, SigMemAct, 0, "mrst_mem_act");
    chk(1, SigIoAct, 0, "mrst_io_act"); chk(1, SigMemIdx, 0, "mrst_mem_idx");
    chk(1, SigDeqIdx, 0, "mrst_head");
`ifdef STAMOFU_AQ_DEQ_CHECK_EN
    chk(1, SigMismatch, 0, "mrst_mismatch");
`endif
    step();
    nRST = 1'b1; idle();
    chk(1, SigOcc, 0, "post_rst_occ");

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) step();
    while (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL %s never sampled: got none expected %0d", exp_q[0].name, exp_q[0].val);
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
